// File: rtl/kt_pkg.sv
// Shared definitions for the countdown timer: field widths, the seconds
// limit, the controller state encoding and the preset-seconds clamp.
package kt_pkg;

  localparam int MIN_W = 7;
  localparam int SEC_W = 6;

  localparam logic [SEC_W-1:0] SEC_MAX = SEC_W'(59);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } state_t;

  // Preset seconds above 59 are pinned to 59
  function automatic logic [SEC_W-1:0] clamp_sec(input logic [SEC_W-1:0] s);
    return (s > SEC_MAX) ? SEC_MAX : s;
  endfunction

endpackage

// File: rtl/mmss_decrement.sv
// Combinational mm:ss minus one second. Seconds borrow from minutes when
// they are at zero. An input of 00:00 is passed through unchanged and
// flagged with o_zero so the caller can tell an empty count apart.
module mmss_decrement
  import kt_pkg::*;
(
  input  logic [MIN_W-1:0] i_min,
  input  logic [SEC_W-1:0] i_sec,
  output logic [MIN_W-1:0] o_min,
  output logic [SEC_W-1:0] o_sec,
  output logic             o_zero
);

  // Borrow-and-wrap decrement of the minute:second pair
  always_comb begin
    o_zero = (i_min == '0) && (i_sec == '0);
    o_min  = i_min;
    o_sec  = i_sec;
    if (!o_zero) begin
      if (i_sec == '0) begin
        o_sec = SEC_MAX;
        o_min = i_min - MIN_W'(1);
      end else begin
        o_sec = i_sec - SEC_W'(1);
      end
    end
  end

endmodule

// File: rtl/countdown_core.sv
// Countdown timer core: IDLE / RUN / PAUSE / ALARM controller over a
// registered mm:ss count, decremented once per tick pulse while running.
// Optional feature macro KT_AUTO_SILENCE_EN: when defined, ALARM ends by
// itself on the ALARM_TICKS-th tick; otherwise ALARM holds until clear,
// load or reset and no alarm tick counter is built.
module countdown_core
  import kt_pkg::*;
#(
  parameter int MAX_MIN     = 99,
  parameter int ALARM_TICKS = 30
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             tick,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic             clear,
  input  logic [MIN_W-1:0] load_min,
  input  logic [SEC_W-1:0] load_sec,
  output logic [MIN_W-1:0] min,
  output logic [SEC_W-1:0] sec,
  output logic             running,
  output logic             alarm,
  output logic             done
);

  localparam logic [MIN_W-1:0] MAX_MIN_L = MIN_W'(MAX_MIN);

  state_t           r_state;
  logic [MIN_W-1:0] r_min;
  logic [SEC_W-1:0] r_sec;
  logic             r_done;

`ifdef KT_AUTO_SILENCE_EN
  localparam int               ACNT_W    = $clog2(ALARM_TICKS + 1);
  localparam logic [ACNT_W-1:0] ACNT_LAST = ACNT_W'(ALARM_TICKS - 1);
  logic [ACNT_W-1:0] r_acnt;
`endif

  logic [MIN_W-1:0] w_dec_min;
  logic [SEC_W-1:0] w_dec_sec;
  logic             w_zero;
  logic             w_expire;
  logic [MIN_W-1:0] w_ld_min;
  logic [SEC_W-1:0] w_ld_sec;

  mmss_decrement u_dec (
    .i_min  (r_min),
    .i_sec  (r_sec),
    .o_min  (w_dec_min),
    .o_sec  (w_dec_sec),
    .o_zero (w_zero)
  );

  // The tick that lands on 00:00 is the expiry tick
  assign w_expire = (w_dec_min == '0) && (w_dec_sec == '0);

  // Preset clamped into the legal display range
  assign w_ld_min = (load_min > MAX_MIN_L) ? MAX_MIN_L : load_min;
  assign w_ld_sec = clamp_sec(load_sec);

  // Controller: state, count, expiry pulse and (optionally) alarm tick count
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_min   <= '0;
      r_sec   <= '0;
      r_done  <= 1'b0;
`ifdef KT_AUTO_SILENCE_EN
      r_acnt  <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE, ST_PAUSE: begin
          // load takes priority; stop blocks start, and a start on an
          // empty count is dropped
          if (load) begin
            r_min   <= w_ld_min;
            r_sec   <= w_ld_sec;
            r_state <= ST_IDLE;
          end else if (start && !stop && !w_zero) begin
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          // A stop swallows a coincident tick; load and start are ignored
          if (stop) begin
            r_state <= ST_PAUSE;
          end else if (tick) begin
            r_min <= w_dec_min;
            r_sec <= w_dec_sec;
            if (w_expire) begin
              r_state <= ST_ALARM;
              r_done  <= 1'b1;
`ifdef KT_AUTO_SILENCE_EN
              r_acnt  <= '0;
`endif
            end
          end
        end
        ST_ALARM: begin
          if (load) begin
            r_min   <= w_ld_min;
            r_sec   <= w_ld_sec;
            r_state <= ST_IDLE;
          end else if (clear) begin
            r_state <= ST_IDLE;
          end
`ifdef KT_AUTO_SILENCE_EN
          else if (tick) begin
            if (r_acnt == ACNT_LAST) begin
              r_state <= ST_IDLE;
              r_acnt  <= '0;
            end else begin
              r_acnt <= r_acnt + ACNT_W'(1);
            end
          end
`endif
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign min     = r_min;
  assign sec     = r_sec;
  assign done    = r_done;
  assign running = (r_state == ST_RUN);
  assign alarm   = (r_state == ST_ALARM);

endmodule
